regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_pkg.sv | 16 +
 rtl/regfile_mp_init.sv | 65 ++++++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_mp_pkg;

    // Array lifecycle: INIT zeroes the array one entry per cycle, RUN serves traffic.
    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;
    localparam int NRD_D   = 2;

endpackage

// File: rtl/regfile_mp_init.sv
// INIT/RUN controller: sweeps every register to zero, then raises ready.
// Latency: ready rises NREGS cycles after reset release or after a RUN clear.
// Backpressure: none; clr_req is ignored while the sweep is running.
module regfile_mp_init
    import regfile_mp_pkg::*;
#(
    parameter int NREGS = NREGS_D
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    output logic                     ready,
    output logic                     sweep_we,
    output logic [$clog2(NREGS)-1:0] sweep_idx
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_t     state, state_nx;
    logic [AW-1:0] idx, idx_nx;

    // State and sweep index; reset always restarts the sweep from entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_INIT;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Next-state: walk the index during INIT, drop back to INIT on a RUN clear.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        sweep_we = 1'b0;
        case (state)
            RF_INIT: begin
                sweep_we = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nx = RF_RUN;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + AW'(1);
                end
            end
            RF_RUN: begin
                if (clr_req) begin
                    state_nx = RF_INIT;
                    idx_nx   = '0;
                end
            end
            default: begin
                state_nx = RF_INIT;
                idx_nx   = '0;
            end
        endcase
    end

    assign ready     = (state == RF_RUN);
    assign sweep_idx = idx;

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NRD-read register file with hardwired-zero r0 and an INIT zeroing sweep.
// Latency: writes visible next cycle (same cycle when REGFILE_MP_BYPASS_EN is defined); reads combinational.
// Backpressure: writes are dropped while ready=0; a RUN clear discards same-cycle writes.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN  = XLEN_D,
    parameter int NREGS = NREGS_D,
    parameter int NRD   = NRD_D
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr_req,
    output logic                               ready,
    input  logic [1:0]                         we,
    input  logic [$clog2(NREGS)-1:0]           waddr0,
    input  logic [XLEN-1:0]                    wdata0,
    input  logic [$clog2(NREGS)-1:0]           waddr1,
    input  logic [XLEN-1:0]                    wdata1,
    input  logic [NRD*$clog2(NREGS)-1:0]       raddr,
    output logic [NRD*XLEN-1:0]                rdata,
    output logic                               wcoll
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] mem [NREGS];
    logic            sweep_we;
    logic [AW-1:0]   sweep_idx;
    logic            wen0, wen1;

    regfile_mp_init #(
        .NREGS (NREGS)
    ) u_init (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .ready     (ready),
        .sweep_we  (sweep_we),
        .sweep_idx (sweep_idx)
    );

    // Effective enables: only in RUN, not during a clear, never to r0.
    assign wen0 = ready && !clr_req && we[0] && (waddr0 != '0);
    assign wen1 = ready && !clr_req && we[1] && (waddr1 != '0);

    // Array update: sweep zeroes during INIT; port 1 written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_idx] <= '0;
        end else begin
            if (wen0) mem[waddr0] <= wdata0;
            if (wen1) mem[waddr1] <= wdata1;
        end
    end

    // One-cycle pulse after both ports hit the same nonzero register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcoll <= 1'b0;
        end else begin
            wcoll <= wen0 && wen1 && (waddr0 == waddr1);
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rv;

        assign ra = raddr[i*AW +: AW];

        // Read mux: zero for r0 and during INIT, optional same-cycle forwarding.
        always_comb begin
            rv = mem[ra];
            if ((ra == '0) || !ready) begin
                rv = '0;
`ifdef REGFILE_MP_BYPASS_EN
            end else if (wen1 && (waddr1 == ra)) begin
                rv = wdata1;
            end else if (wen0 && (waddr0 == ra)) begin
                rv = wdata0;
`endif
            end
        end

        assign rdata[i*XLEN +: XLEN] = rv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clr_req;
    logic                 ready;
    logic [1:0]           we;
    logic [AW-1:0]        waddr0, waddr1;
    logic [XLEN-1:0]      wdata0, wdata1;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*XLEN-1:0]  rdata;
    logic                 wcoll;

    int total = 0;
    int bad   = 0;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .ready   (ready),
        .we      (we),
        .waddr0  (waddr0),
        .wdata0  (wdata0),
        .waddr1  (waddr1),
        .wdata1  (wdata1),
        .raddr   (raddr),
        .rdata   (rdata),
        .wcoll   (wcoll)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    function automatic logic [31:0] rd0();
        return rdata[0 +: XLEN];
    endfunction

    function automatic logic [31:0] rd1();
        return rdata[XLEN +: XLEN];
    endfunction

    initial begin
        rst_n   = 1'b0;
        clr_req = 1'b0;
        we      = 2'b00;
        waddr0  = '0;
        waddr1  = '0;
        wdata0  = '0;
        wdata1  = '0;
        raddr   = '0;

        // Reset state
        repeat (3) tick();
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_wcoll", {31'd0, wcoll}, 32'd0);

        // Release reset: ready must rise on exactly the 32nd edge
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("boot_ready_c%0d", k), {31'd0, ready}, (k >= 32) ? 32'd1 : 32'd0);
        end

        // Every register reads zero after the sweep
        for (int r = 0; r < NREGS; r++) begin
            set_rd(AW'(r), AW'(NREGS - 1 - r));
            chk($sformatf("zero_p0_r%0d", r), rd0(), 32'd0);
            chk($sformatf("zero_p1_r%0d", NREGS - 1 - r), rd1(), 32'd0);
        end

        // Port 0 write, read back next cycle
        we = 2'b01; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        tick();
        we = 2'b00;
        set_rd(5'd5, 5'd5);
        chk("wr5_p0", rd0(), 32'hDEADBEEF);
        chk("wr5_p1", rd1(), 32'hDEADBEEF);

        // Writes to r0 on both ports are dropped and raise no collision
        we = 2'b11; waddr0 = 5'd0; wdata0 = 32'h1234; waddr1 = 5'd0; wdata1 = 32'h1234;
        tick();
        we = 2'b00;
        set_rd(5'd0, 5'd5);
        chk("r0_read", rd0(), 32'd0);
        chk("r0_no_wcoll", {31'd0, wcoll}, 32'd0);
        chk("r5_intact", rd1(), 32'hDEADBEEF);

        // Collision on r7: port 1 wins, wcoll pulses for one cycle
        we = 2'b11; waddr0 = 5'd7; wdata0 = 32'h1111; waddr1 = 5'd7; wdata1 = 32'h2222;
        tick();
        we = 2'b00;
        chk("coll_wcoll_hi", {31'd0, wcoll}, 32'd1);
        set_rd(5'd7, 5'd0);
        chk("coll_r7", rd0(), 32'h2222);
        tick();
        chk("coll_wcoll_lo", {31'd0, wcoll}, 32'd0);

        // Both ports to distinct registers
        we = 2'b11; waddr0 = 5'd4; wdata0 = 32'h44; waddr1 = 5'd6; wdata1 = 32'h66;
        tick();
        we = 2'b00;
        set_rd(5'd4, 5'd6);
        chk("dual_r4", rd0(), 32'h44);
        chk("dual_r6", rd1(), 32'h66);
        chk("dual_no_wcoll", {31'd0, wcoll}, 32'd0);

        // Same-cycle write/read of r3
        we = 2'b01; waddr0 = 5'd3; wdata0 = 32'h5555;
        tick();
        we = 2'b00;
        set_rd(5'd3, 5'd7);
        chk("r3_pre", rd0(), 32'h5555);
        we = 2'b01; waddr0 = 5'd3; wdata0 = 32'hAAAA;
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        chk("r3_same_cycle", rd0(), 32'hAAAA);
`else
        chk("r3_same_cycle", rd0(), 32'h5555);
`endif
        tick();
        we = 2'b00;
        #1;
        chk("r3_next_cycle", rd0(), 32'hAAAA);

        // Soft clear from RUN with a write in the same cycle
        we = 2'b01; waddr0 = 5'd9; wdata0 = 32'h77;
        tick();
        we = 2'b00;
        set_rd(5'd9, 5'd10);
        chk("r9_before_clr", rd0(), 32'h77);
        clr_req = 1'b1;
        we = 2'b01; waddr0 = 5'd10; wdata0 = 32'h99;
        tick();
        clr_req = 1'b0;
        we = 2'b00;
        #1;
        chk("clr_ready_drop", {31'd0, ready}, 32'd0);
        chk("clr_r9_init", rd0(), 32'd0);

        // Sweep after clear: clr_req pulse and colliding writes mid-INIT are ignored
        for (int k = 1; k <= 32; k++) begin
            clr_req = (k == 5);
            we = 2'b11; waddr0 = 5'd12; wdata0 = 32'hC0; waddr1 = 5'd12; wdata1 = 32'hC1;
            tick();
            chk($sformatf("clr_ready_c%0d", k), {31'd0, ready}, (k >= 32) ? 32'd1 : 32'd0);
            chk($sformatf("clr_wcoll_c%0d", k), {31'd0, wcoll}, 32'd0);
        end
        clr_req = 1'b0;
        we = 2'b00;
        set_rd(5'd9, 5'd10);
        chk("clr_r9_after", rd0(), 32'd0);
        chk("clr_r10_discard", rd1(), 32'd0);
        set_rd(5'd12, 5'd5);
        chk("init_r12_ignored", rd0(), 32'd0);
        chk("clr_r5_zeroed", rd1(), 32'd0);

        // Reset pulse at sweep index 10
        we = 2'b01; waddr0 = 5'd2; wdata0 = 32'h22;
        tick();
        we = 2'b00;
        set_rd(5'd2, 5'd0);
        chk("r2_written", rd0(), 32'h22);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #2;
        chk("rst_mid_ready", {31'd0, ready}, 32'd0);
        chk("rst_mid_wcoll", {31'd0, wcoll}, 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("rst_ready_c%0d", k), {31'd0, ready}, (k >= 32) ? 32'd1 : 32'd0);
        end
        set_rd(5'd2, 5'd7);
        chk("rst_r2_zero", rd0(), 32'd0);
        chk("rst_r7_zero", rd1(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
